// File: rtl/i2c_master_arbiter_if.sv
// Engine-side bus of the I2C master arbiter: transaction descriptor, start/abort,
// byte-level write/read handshakes and completion status.
// The master modport is the arbiter's view; the slave modport is the engine's view.
interface i2c_master_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8
);
   logic                  eng_start_o;
   logic [DATA_WIDTH-2:0] eng_addr_o;
   logic                  eng_rw_o;
   logic [LEN_WIDTH-1:0]  eng_len_o;
   logic                  eng_abort_o;
   logic [DATA_WIDTH-1:0] eng_wdata_o;
   logic                  eng_wdata_req_i;
   logic [DATA_WIDTH-1:0] eng_rdata_i;
   logic                  eng_rdata_vld_i;
   logic                  eng_done_i;
   logic                  eng_nack_i;

   modport master (
      output eng_start_o, eng_addr_o, eng_rw_o, eng_len_o, eng_abort_o, eng_wdata_o,
      input  eng_wdata_req_i, eng_rdata_i, eng_rdata_vld_i, eng_done_i, eng_nack_i
   );

   modport slave (
      input  eng_start_o, eng_addr_o, eng_rw_o, eng_len_o, eng_abort_o, eng_wdata_o,
      output eng_wdata_req_i, eng_rdata_i, eng_rdata_vld_i, eng_done_i, eng_nack_i
   );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one byte-level I2C master
// engine between REQ_NUM requesters. Latches the winner's descriptor, starts the
// engine, routes write/read bytes to the granted requester and returns done/NACK.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to build the TIMEOUT_WIDTH counter
// that aborts a silent engine; without it eng_abort_o and timeout_o are tied 0.
module i2c_master_arbiter #(
   parameter int REQ_NUM       = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int LEN_WIDTH     = 8,
   parameter int TIMEOUT_WIDTH = 16
) (
   input  logic                            clk_i,
   input  logic                            s_rst_i,
   input  logic [REQ_NUM-1:0]              req_i,
   input  logic [REQ_NUM*(DATA_WIDTH-1)-1:0] addr_i,
   input  logic [REQ_NUM-1:0]              rw_i,
   input  logic [REQ_NUM*LEN_WIDTH-1:0]    len_i,
   input  logic [REQ_NUM*DATA_WIDTH-1:0]   wdata_i,
   output logic [REQ_NUM-1:0]              grant_o,
   output logic [REQ_NUM-1:0]              wdata_req_o,
   output logic [DATA_WIDTH-1:0]           rdata_o,
   output logic [REQ_NUM-1:0]              rdata_vld_o,
   output logic [REQ_NUM-1:0]              done_o,
   output logic                            nack_o,
   output logic                            timeout_o,
   i2c_master_arbiter_if.master            eng
);
   localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQ_NUM - 1);

   typedef enum logic [2:0] {S_IDLE, S_GRANT, S_START, S_XFER, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]      gnt_idx_q, gnt_idx_d;
   logic [REQ_NUM-1:0]    grant_q, grant_d;
   logic [DATA_WIDTH-2:0] addr_q, addr_d;
   logic                  rw_q, rw_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic                  start_q, start_d;
   logic [REQ_NUM-1:0]    done_q, done_d;
   logic                  nack_lat_q, nack_lat_d;
   logic                  nack_q, nack_d;
   logic                  in_xfer;
`ifdef I2C_ARB_TIMEOUT_EN
   logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
   logic                     to_lat_q, to_lat_d;
   logic                     timeout_q, timeout_d;
   logic                     abort_q, abort_d;
`endif

   // First requesting index at or after ptr, wrapping modulo REQ_NUM.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [REQ_NUM-1:0] req,
                                                input logic [IDX_W-1:0]   ptr);
      int sum;
      logic [IDX_W-1:0] pick;
      pick = ptr;
      for (int k = REQ_NUM - 1; k >= 0; k--) begin
         sum = int'(ptr) + k;
         if (sum >= REQ_NUM) sum = sum - REQ_NUM;
         if (req[sum]) pick = sum[IDX_W-1:0];
      end
      return pick;
   endfunction

   // Next-state logic: arbitration, descriptor latch, sequencing and status.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_idx_d  = gnt_idx_q;
      grant_d    = grant_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      len_d      = len_q;
      start_d    = 1'b0;
      done_d     = '0;
      nack_lat_d = nack_lat_q;
      nack_d     = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      to_lat_d   = to_lat_q;
      timeout_d  = 1'b0;
      abort_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (|req_i) begin
               gnt_idx_d          = rr_pick(req_i, rr_ptr_q);
               grant_d            = '0;
               grant_d[gnt_idx_d] = 1'b1;
               addr_d             = addr_i[gnt_idx_d*(DATA_WIDTH-1) +: (DATA_WIDTH-1)];
               rw_d               = rw_i[gnt_idx_d];
               len_d              = len_i[gnt_idx_d*LEN_WIDTH +: LEN_WIDTH];
               state_d            = S_GRANT;
            end
         end
         S_GRANT: begin
            start_d = 1'b1;
            state_d = S_START;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_START: state_d = S_XFER;
         S_XFER: begin
            if (eng.eng_done_i) begin
               nack_lat_d = eng.eng_nack_i;
               state_d    = S_DONE;
`ifdef I2C_ARB_TIMEOUT_EN
               to_lat_d   = 1'b0;
            end else if (eng.eng_wdata_req_i || eng.eng_rdata_vld_i) begin
               cnt_d = '0;
            end else if (&cnt_q) begin
               // Silent engine: abort now, report timeout on the done pulse.
               abort_d    = 1'b1;
               to_lat_d   = 1'b1;
               nack_lat_d = 1'b0;
               state_d    = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         S_DONE: begin
            done_d   = grant_q;
            nack_d   = nack_lat_q;
            grant_d  = '0;
            rr_ptr_d = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + 1'b1;
            state_d  = S_IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
            timeout_d = to_lat_q;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, descriptor and registered-output flops; synchronous reset clears all.
   always_ff @(posedge clk_i) begin
      if (s_rst_i) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         gnt_idx_q  <= '0;
         grant_q    <= '0;
         addr_q     <= '0;
         rw_q       <= 1'b0;
         len_q      <= '0;
         start_q    <= 1'b0;
         done_q     <= '0;
         nack_lat_q <= 1'b0;
         nack_q     <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         to_lat_q   <= 1'b0;
         timeout_q  <= 1'b0;
         abort_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         gnt_idx_q  <= gnt_idx_d;
         grant_q    <= grant_d;
         addr_q     <= addr_d;
         rw_q       <= rw_d;
         len_q      <= len_d;
         start_q    <= start_d;
         done_q     <= done_d;
         nack_lat_q <= nack_lat_d;
         nack_q     <= nack_d;
`ifdef I2C_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         to_lat_q   <= to_lat_d;
         timeout_q  <= timeout_d;
         abort_q    <= abort_d;
`endif
      end
   end

   assign in_xfer = (state_q == S_XFER);

   // Zero-latency byte routing between the engine and the granted requester.
   always_comb begin
      wdata_req_o     = (in_xfer && eng.eng_wdata_req_i) ? grant_q : '0;
      rdata_vld_o     = (in_xfer && eng.eng_rdata_vld_i) ? grant_q : '0;
      rdata_o         = in_xfer ? eng.eng_rdata_i : '0;
      eng.eng_wdata_o = in_xfer ? wdata_i[gnt_idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
   end

   assign grant_o         = grant_q;
   assign done_o          = done_q;
   assign nack_o          = nack_q;
   assign eng.eng_start_o = start_q;
   assign eng.eng_addr_o  = addr_q;
   assign eng.eng_rw_o    = rw_q;
   assign eng.eng_len_o   = len_q;
`ifdef I2C_ARB_TIMEOUT_EN
   assign eng.eng_abort_o = abort_q;
   assign timeout_o       = timeout_q;
`else
   assign eng.eng_abort_o = 1'b0;
   assign timeout_o       = 1'b0;
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = TIMEOUT_WIDTH;
`endif
endmodule
